// File: rtl/bcpu_mem_responder_if.sv
// rtl/bcpu_mem_responder_if.sv - effective-address request/response bus for bcpu_mem_responder
//
// Request channel (master -> slave): req_valid, req_we, req_addr, req_wdata, req_thread; req_ready back.
// Response channel (slave -> master): resp_valid, resp_we, resp_thread, resp_rdata, resp_err; resp_ready back.
// master = CPU load/store stage, slave = memory responder.
interface bcpu_mem_responder_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int THREAD_BITS = 2
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic [THREAD_BITS-1:0] req_thread;

    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_we;
    logic [THREAD_BITS-1:0] resp_thread;
    logic [DATA_WIDTH-1:0]  resp_rdata;
    logic                   resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_thread, resp_ready,
        input  req_ready, resp_valid, resp_we, resp_thread, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_thread, resp_ready,
        output req_ready, resp_valid, resp_we, resp_thread, resp_rdata, resp_err
    );
endinterface

// File: rtl/bcpu_mem_responder.sv
// rtl/bcpu_mem_responder.sv - two-stage in-order memory responder for BCPU16 load/store requests
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - bcpu_mem_responder_if.slave (request in, tagged response out)
// Optional feature macro: BCPU_MEM_WRITE_PROTECT_EN
//   defined   : stores below PROTECT_LIMIT fault and leave the RAM untouched
//   undefined : every in-range store writes
module bcpu_mem_responder #(
    parameter int          ADDR_WIDTH    = 10,
    parameter int          DATA_WIDTH    = 16,
    parameter int          THREAD_BITS   = 2,
    parameter int unsigned MEM_SIZE      = 1024,
    parameter int unsigned PROTECT_LIMIT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    bcpu_mem_responder_if.slave   bus
);

    // RAM array; contents are deliberately not reset
    logic [DATA_WIDTH-1:0]  mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]  ram_rdata_q;

    // S1: access stage
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_we_q, s1_we_d;
    logic                   s1_err_q, s1_err_d;
    logic [THREAD_BITS-1:0] s1_thread_q, s1_thread_d;

    // S2: output register
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_we_q, resp_we_d;
    logic                   resp_err_q, resp_err_d;
    logic [THREAD_BITS-1:0] resp_thread_q, resp_thread_d;
    logic [DATA_WIDTH-1:0]  resp_rdata_q, resp_rdata_d;

    logic [31:0] addr_ext;
    logic        out_of_range;
    logic        wr_protected;
    logic        fault;
    logic        s2_load;
    logic        req_ready;
    logic        accept;

    assign addr_ext     = 32'(bus.req_addr);
    assign out_of_range = addr_ext >= MEM_SIZE;

`ifdef BCPU_MEM_WRITE_PROTECT_EN
    assign wr_protected = bus.req_we && (addr_ext < PROTECT_LIMIT);
`else
    assign wr_protected = 1'b0;
`endif

    assign fault = out_of_range || wr_protected;

    // S2 can take new contents when empty or draining this cycle; S1 can then
    // move forward, which also frees S1 for a new request in the same cycle.
    assign s2_load   = !resp_valid_q || bus.resp_ready;
    // Held low during reset so nothing is written to the RAM while rst_i is high.
    assign req_ready = !rst_i && (!s1_valid_q || s2_load);
    assign accept    = bus.req_valid && req_ready;

    // Read and write only on accept, so a stalled S1 keeps its captured data.
    // A load accepted right after a store sees the stored word because the
    // store has already landed at the earlier edge.
    always_ff @(posedge clk_i) begin
        if (accept && !fault) begin
            if (bus.req_we) begin
                mem_q[bus.req_addr] <= bus.req_wdata;
            end else begin
                ram_rdata_q <= mem_q[bus.req_addr];
            end
        end
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_we_d       = s1_we_q;
        s1_err_d      = s1_err_q;
        s1_thread_d   = s1_thread_q;
        resp_valid_d  = resp_valid_q;
        resp_we_d     = resp_we_q;
        resp_err_d    = resp_err_q;
        resp_thread_d = resp_thread_q;
        resp_rdata_d  = resp_rdata_q;

        if (s2_load) begin
            resp_valid_d = s1_valid_q;
            // Leave S2 fields untouched when it goes empty; they are don't-care then.
            if (s1_valid_q) begin
                resp_we_d     = s1_we_q;
                resp_err_d    = s1_err_q;
                resp_thread_d = s1_thread_q;
                resp_rdata_d  = (s1_we_q || s1_err_q) ? '0 : ram_rdata_q;
            end
        end

        if (req_ready) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_we_d     = bus.req_we;
                s1_err_d    = fault;
                s1_thread_d = bus.req_thread;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q    <= 1'b0;
            s1_we_q       <= 1'b0;
            s1_err_q      <= 1'b0;
            s1_thread_q   <= '0;
            resp_valid_q  <= 1'b0;
            resp_we_q     <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_thread_q <= '0;
            resp_rdata_q  <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_we_q       <= s1_we_d;
            s1_err_q      <= s1_err_d;
            s1_thread_q   <= s1_thread_d;
            resp_valid_q  <= resp_valid_d;
            resp_we_q     <= resp_we_d;
            resp_err_q    <= resp_err_d;
            resp_thread_q <= resp_thread_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_we     = resp_we_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_thread = resp_thread_q;
    assign bus.resp_rdata  = resp_rdata_q;

endmodule
